// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy bit + ROB tag).
// Optional macro COMMIT_BYPASS_EN forwards a same-cycle matching commit to the read ports.
module reg_status_file #(
  parameter int REG_NUM     = 32,
  parameter int ENTRY_WIDTH = 5,
  parameter int XLEN        = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   roll_back,
  input  logic                   rename_en,
  input  logic [4:0]             rename_rd,
  input  logic [ENTRY_WIDTH-1:0] rename_entry,
  input  logic [4:0]             rs1_idx,
  input  logic [4:0]             rs2_idx,
  output logic [XLEN-1:0]        rs1_val,
  output logic                   rs1_busy,
  output logic [ENTRY_WIDTH-1:0] rs1_tag,
  output logic [XLEN-1:0]        rs2_val,
  output logic                   rs2_busy,
  output logic [ENTRY_WIDTH-1:0] rs2_tag,
  input  logic                   rob_commit,
  input  logic                   rob_rd_valid,
  input  logic [4:0]             rob_rd_commit,
  input  logic [ENTRY_WIDTH-1:0] rob_entry_commit,
  input  logic [XLEN-1:0]        rob_result_commit
);

  logic [XLEN-1:0]        r_value [REG_NUM];
  logic                   r_busy  [REG_NUM];
  logic [ENTRY_WIDTH-1:0] r_tag   [REG_NUM];

  logic w_commit_wr;
  logic w_rename_wr;

  assign w_commit_wr = rob_commit && rob_rd_valid && (rob_rd_commit != 5'd0);
  assign w_rename_wr = rename_en && (rename_rd != 5'd0);

  // Later assignments override earlier ones: rollback beats rename, rename beats a commit's busy clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= '0;
        r_busy[i]  <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit_wr) begin
        r_value[rob_rd_commit] <= rob_result_commit;
        if (r_busy[rob_rd_commit] && (r_tag[rob_rd_commit] == rob_entry_commit))
          r_busy[rob_rd_commit] <= 1'b0;
      end
      if (roll_back) begin
        for (int i = 0; i < REG_NUM; i++)
          r_busy[i] <= 1'b0;
      end else if (w_rename_wr) begin
        r_busy[rename_rd] <= 1'b1;
        r_tag[rename_rd]  <= rename_entry;
      end
    end
  end

`ifdef COMMIT_BYPASS_EN
  logic w_bypass1;
  logic w_bypass2;

  assign w_bypass1 = w_commit_wr && !roll_back && (rob_rd_commit == rs1_idx) &&
                     r_busy[rs1_idx] && (r_tag[rs1_idx] == rob_entry_commit);
  assign w_bypass2 = w_commit_wr && !roll_back && (rob_rd_commit == rs2_idx) &&
                     r_busy[rs2_idx] && (r_tag[rs2_idx] == rob_entry_commit);
`endif

  always_comb begin
    rs1_val  = '0;
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    if (rs1_idx != 5'd0) begin
      rs1_val  = r_value[rs1_idx];
      rs1_busy = r_busy[rs1_idx];
      rs1_tag  = r_tag[rs1_idx];
`ifdef COMMIT_BYPASS_EN
      if (w_bypass1) begin
        rs1_val  = rob_result_commit;
        rs1_busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rs2_val  = '0;
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    if (rs2_idx != 5'd0) begin
      rs2_val  = r_value[rs2_idx];
      rs2_busy = r_busy[rs2_idx];
      rs2_tag  = r_tag[rs2_idx];
`ifdef COMMIT_BYPASS_EN
      if (w_bypass2) begin
        rs2_val  = rob_result_commit;
        rs2_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: directed rename/commit/rollback scenarios plus a random run
// against a behavioural model; honours COMMIT_BYPASS_EN when defined.
module tb_reg_status_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, rename_en;
  logic [4:0]  rename_rd, rename_entry, rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_tag, rs2_tag;
  logic        rob_commit, rob_rd_valid;
  logic [4:0]  rob_rd_commit, rob_entry_commit;
  logic [31:0] rob_result_commit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy, rb, ren;
    logic [4:0]  rrd, rent;
    logic        com, cval;
    logic [4:0]  crd, cent;
    logic [31:0] cres;
    logic [4:0]  r1, r2;
  } stim_t;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] val;
    logic        busy;
    logic [4:0]  tag;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] mVal  [32];
  logic        mBusy [32];
  logic [4:0]  mTag  [32];

  always #5 clk_in = ~clk_in;

  reg_status_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_entry(rename_entry),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .rob_commit(rob_commit), .rob_rd_valid(rob_rd_valid), .rob_rd_commit(rob_rd_commit),
    .rob_entry_commit(rob_entry_commit), .rob_result_commit(rob_result_commit)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rdy: 1'b1, rb: 1'b0, ren: 1'b0, rrd: 5'd0, rent: 5'd0, com: 1'b0, cval: 1'b0,
          crd: 5'd0, cent: 5'd0, cres: 32'd0, r1: 5'd0, r2: 5'd0};
    return s;
  endfunction

  // Expected combinational read of the model for the stimulus currently on the pins.
  function automatic exp_t modelRead(input string name, input int port, input logic [4:0] idx, input stim_t s);
    exp_t e;
    e.name = name;
    e.port = port;
    e.val  = 32'd0;
    e.busy = 1'b0;
    e.tag  = 5'd0;
    if (idx != 5'd0) begin
      e.val  = mVal[idx];
      e.busy = mBusy[idx];
      e.tag  = mTag[idx];
`ifdef COMMIT_BYPASS_EN
      if (s.com && s.cval && s.crd == idx && !s.rb && mBusy[idx] && mTag[idx] == s.cent) begin
        e.val  = s.cres;
        e.busy = 1'b0;
      end
`endif
    end
    return e;
  endfunction

  task automatic updateModel(input stim_t s);
    if (!s.rdy) return;
    if (s.com && s.cval && s.crd != 5'd0) begin
      mVal[s.crd] = s.cres;
      if (mBusy[s.crd] && mTag[s.crd] == s.cent) mBusy[s.crd] = 1'b0;
    end
    if (s.rb) begin
      for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
    end else if (s.ren && s.rrd != 5'd0) begin
      mBusy[s.rrd] = 1'b1;
      mTag[s.rrd]  = s.rent;
    end
  endtask

  task automatic drive(input stim_t s);
    rdy_in = s.rdy; roll_back = s.rb; rename_en = s.ren; rename_rd = s.rrd; rename_entry = s.rent;
    rob_commit = s.com; rob_rd_valid = s.cval; rob_rd_commit = s.crd; rob_entry_commit = s.cent;
    rob_result_commit = s.cres; rs1_idx = s.r1; rs2_idx = s.r2;
  endtask

  // Drain the scoreboard against the read ports while they are stable.
  task automatic compareQueue();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.port == 1) begin
        checkOutput({e.name, ".val"}, rs1_val, e.val);
        checkOutput({e.name, ".busy"}, {31'd0, rs1_busy}, {31'd0, e.busy});
        checkOutput({e.name, ".tag"}, {27'd0, rs1_tag}, {27'd0, e.tag});
      end else begin
        checkOutput({e.name, ".val"}, rs2_val, e.val);
        checkOutput({e.name, ".busy"}, {31'd0, rs2_busy}, {31'd0, e.busy});
        checkOutput({e.name, ".tag"}, {27'd0, rs2_tag}, {27'd0, e.tag});
      end
    end
  endtask

  task automatic finishCycle(input stim_t s);
    #2;
    compareQueue();
    @(posedge clk_in);
    updateModel(s);
    #1;
  endtask

  task automatic applyStimulus(input string name, input stim_t s);
    drive(s);
    sbq.push_back(modelRead({name, ".rs1"}, 1, s.r1, s));
    sbq.push_back(modelRead({name, ".rs2"}, 2, s.r2, s));
    finishCycle(s);
  endtask

  // Idle cycle reading idx on rs1 and x0 on rs2 against hand-written constants.
  task automatic readConst(input string name, input logic [4:0] idx, input logic [31:0] v,
                           input logic b, input logic [4:0] t);
    stim_t s;
    exp_t e;
    s = idle();
    s.r1 = idx;
    drive(s);
    e = '{name: name, port: 1, val: v, busy: b, tag: t};
    sbq.push_back(e);
    e = '{name: {name, ".x0"}, port: 2, val: 32'd0, busy: 1'b0, tag: 5'd0};
    sbq.push_back(e);
    finishCycle(s);
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < 32; i++) begin
      mVal[i] = 32'd0; mBusy[i] = 1'b0; mTag[i] = 5'd0;
    end
    drive(idle());
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    readConst("reset_x5", 5'd5, 32'd0, 1'b0, 5'd0);
    s = idle(); s.r1 = 5'd31; s.r2 = 5'd0;
    applyStimulus("reset_model", s);

    s = idle(); s.ren = 1'b1; s.rrd = 5'd3; s.rent = 5'd7; s.r1 = 5'd3;
    applyStimulus("rename_x3_own", s);
    readConst("x3_busy", 5'd3, 32'd0, 1'b1, 5'd7);
    s = idle(); s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd3; s.cent = 5'd7; s.cres = 32'hDEADBEEF; s.r1 = 5'd3;
    applyStimulus("commit_x3_same", s);
    readConst("x3_done", 5'd3, 32'hDEADBEEF, 1'b0, 5'd7);

    s = idle(); s.ren = 1'b1; s.rrd = 5'd4; s.rent = 5'd2;
    applyStimulus("rename_x4_t2", s);
    s.rent = 5'd9;
    applyStimulus("rename_x4_t9", s);
    s = idle(); s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd4; s.cent = 5'd2; s.cres = 32'h11;
    applyStimulus("stale_commit", s);
    readConst("x4_stale", 5'd4, 32'h11, 1'b1, 5'd9);
    s.cent = 5'd9; s.cres = 32'h22;
    applyStimulus("fresh_commit", s);
    readConst("x4_done", 5'd4, 32'h22, 1'b0, 5'd9);

    s = idle(); s.ren = 1'b1; s.rrd = 5'd6; s.rent = 5'd1;
    applyStimulus("rename_x6", s);
    s = idle(); s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd6; s.cent = 5'd1; s.cres = 32'h55;
    s.ren = 1'b1; s.rrd = 5'd6; s.rent = 5'd4;
    applyStimulus("x6_commit_rename", s);
    readConst("x6_rename_wins", 5'd6, 32'h55, 1'b1, 5'd4);

    s = idle(); s.ren = 1'b1; s.rrd = 5'd1; s.rent = 5'd3;
    applyStimulus("rename_x1", s);
    s.rrd = 5'd2; s.rent = 5'd4;
    applyStimulus("rename_x2", s);
    s = idle(); s.rb = 1'b1; s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd1; s.cent = 5'd3; s.cres = 32'hAA;
    s.ren = 1'b1; s.rrd = 5'd5; s.rent = 5'd6; s.r1 = 5'd1; s.r2 = 5'd2;
    applyStimulus("rollback", s);
    readConst("x1_rb", 5'd1, 32'hAA, 1'b0, 5'd3);
    readConst("x2_rb", 5'd2, 32'd0, 1'b0, 5'd4);
    readConst("x5_discard", 5'd5, 32'd0, 1'b0, 5'd0);

    s = idle(); s.ren = 1'b1; s.rrd = 5'd0; s.rent = 5'd5;
    s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd0; s.cent = 5'd5; s.cres = 32'h1234;
    applyStimulus("x0_write", s);
    readConst("x0_zero", 5'd0, 32'd0, 1'b0, 5'd0);

    s = idle(); s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd10; s.cent = 5'd3; s.cres = 32'h99;
    applyStimulus("commit_idle_reg", s);
    readConst("x10_val", 5'd10, 32'h99, 1'b0, 5'd0);
    s = idle(); s.com = 1'b1; s.cval = 1'b0; s.crd = 5'd10; s.cres = 32'h77;
    applyStimulus("commit_no_rd", s);
    readConst("x10_kept", 5'd10, 32'h99, 1'b0, 5'd0);

    s = idle(); s.ren = 1'b1; s.rrd = 5'd7; s.rent = 5'd8;
    applyStimulus("rename_x7", s);
    s = idle(); s.rdy = 1'b0; s.com = 1'b1; s.cval = 1'b1; s.crd = 5'd7; s.cent = 5'd8; s.cres = 32'h77;
    s.ren = 1'b1; s.rrd = 5'd9; s.rent = 5'd10; s.r1 = 5'd7; s.r2 = 5'd9;
    applyStimulus("frozen", s);
    readConst("x7_frozen", 5'd7, 32'd0, 1'b1, 5'd8);
    readConst("x9_frozen", 5'd9, 32'd0, 1'b0, 5'd0);
    s.rdy = 1'b1; s.ren = 1'b0;
    applyStimulus("commit_x7_read", s);
    readConst("x7_done", 5'd7, 32'h77, 1'b0, 5'd8);

    for (int n = 0; n < 60; n++) begin
      s.rdy  = ($urandom_range(0, 7) != 0);
      s.rb   = ($urandom_range(0, 11) == 0);
      s.ren  = $urandom_range(0, 1) != 0;
      s.rrd  = 5'($urandom_range(0, 7));
      s.rent = 5'($urandom_range(0, 31));
      s.com  = $urandom_range(0, 1) != 0;
      s.cval = ($urandom_range(0, 3) != 0);
      s.crd  = 5'($urandom_range(0, 7));
      s.cent = (n % 2 == 0) ? mTag[s.crd] : 5'($urandom_range(0, 31));
      s.cres = $urandom;
      s.r1   = 5'($urandom_range(0, 7));
      s.r2   = (n % 3 == 0) ? s.crd : 5'($urandom_range(0, 7));
      applyStimulus("random", s);
    end

    s = idle(); s.ren = 1'b1; s.rrd = 5'd1; s.rent = 5'd2;
    drive(s);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mVal[i] = 32'd0; mBusy[i] = 1'b0; mTag[i] = 5'd0;
    end
    readConst("rst_x4", 5'd4, 32'd0, 1'b0, 5'd0);
    readConst("rst_x1", 5'd1, 32'd0, 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file with per-register rename status: 32 × 32-bit values plus busy bit and ROB tag.
- Consumes the ROB commit broadcast, the other end of the commit interface. Updates architectural state and clears rename tags on commit.
- Issue stage renames destinations and reads source operands, getting either a value or a pending ROB tag.
- Roll back discards all pending renames.

Parameters:
REG_NUM, 32, number of architectural registers (index 0 hardwired zero)
ENTRY_WIDTH, 5, ROB tag width (ROB_SIZE 32)
XLEN, 32, data width

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  ready; state frozen when low
roll_back  input  1  flush all pending renames
rename_en  input  1  issue stage allocates ROB entry writing rd
rename_rd  input  5  destination register of issuing instruction
rename_entry  input  ENTRY_WIDTH  ROB tag assigned to issuing instruction
rs1_idx  input  5  source 1 index
rs2_idx  input  5  source 2 index
rs1_val  output  XLEN  source 1 value (valid when rs1_busy=0)
rs1_busy  output  1  source 1 pending
rs1_tag  output  ENTRY_WIDTH  ROB tag producing source 1
rs2_val  output  XLEN  source 2 value
rs2_busy  output  1  source 2 pending
rs2_tag  output  ENTRY_WIDTH  ROB tag producing source 2
rob_commit  input  1  ROB commits head this cycle
rob_rd_valid  input  1  committed instruction writes rd
rob_rd_commit  input  5  committed rd
rob_entry_commit  input  ENTRY_WIDTH  committed ROB tag
rob_result_commit  input  XLEN  committed result

Behaviour:
- State: value[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (rst_in=1 at posedge): all values 0, busy 0, tags 0. Outputs therefore read val=0, busy=0, tag=0 for every index.
- rdy_in=0: no state change. Reads still combinational.
- Reads: combinational from current state, zero latency. A same-cycle rename is not visible, so an instruction's own rd rename never affects its own sources.
- Index 0: val=0, busy=0, tag=0 always. Writes, renames and commits to x0 are ignored.
- Commit, when rob_commit && rob_rd_valid && rd!=0:
  - value[rd] <= result, unconditionally, because the commit is architectural.
  - busy[rd] <= 0 only if busy[rd] && tag[rd]==rob_entry_commit.
  - Otherwise busy and tag are kept, since a younger rename exists.
- Rename, when rename_en && rd!=0: busy[rd] <= 1, tag[rd] <= rename_entry.
- Same-cycle rename and commit to the same rd:
  - Value updated to the commit result.
  - Rename wins, so busy=1 and tag=rename_entry.
- Roll back at posedge:
  - All busy cleared.
  - Values retained.
  - A same-cycle commit value write still applies.
  - A same-cycle rename is discarded.
- Roll back has priority over rename. Reset has priority over everything.
- Tag wrap-around: tags are compared by equality only. The ROB guarantees that at most one in-flight instruction holds a given tag.
- Implementation is a single always @(posedge clk_in) block plus combinational read muxes.

Optional Feature:
COMMIT_BYPASS_EN
- Defined: a read of register r in the same cycle as a qualifying commit, where rd==r, busy[r], tag[r]==rob_entry_commit and roll_back=0, returns busy=0 and val=rob_result_commit. This saves one cycle of operand wait.
- Undefined: reads reflect registered state only. The consumer sees the value one cycle after commit.

Test Plan:
1. Reset, then read rs1_idx=5, rs2_idx=0 -> val=0, busy=0, tag=0 on both.
2. Rename x3 to tag 7; next cycle read x3 -> busy=1, tag=7. Commit rd=3, entry 7, result 0xDEADBEEF; next cycle -> busy=0, val=0xDEADBEEF.
3. Stale commit:
   - Rename x4 to tag 2, then rename x4 to tag 9.
   - Commit entry 2, result 0x11 -> x4 val=0x11, busy=1, tag=9.
   - Commit entry 9, result 0x22 -> busy=0, val=0x22.
4. Rename and commit of x6 in the same cycle (x6 busy with tag 1; commit entry 1, result 0x55; rename tag 4) -> val=0x55, busy=1, tag=4.
5. Roll back:
   - Rename x1 to tag 3 and x2 to tag 4, then assert roll_back with a same-cycle commit of rd=1, entry 3, result 0xAA.
   - Next cycle: x1 busy=0, val=0xAA; x2 busy=0, val unchanged.
   - Writes to x0 (rename or commit with result 0x1234) -> x0 reads 0, busy=0.
6. rdy_in=0 while commit and rename are asserted -> no state change. With COMMIT_BYPASS_EN defined, a same-cycle read of a committing busy register returns busy=0 and the commit value.
